// File: rtl/vit_k3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vit_k3_pkg
// Brief    : Shared types and helpers for the K=3 (4-state) Viterbi decoder.
// Revision : 1.0 - initial release
// ============================================================================
package vit_k3_pkg;

  localparam int NUM_STATES = 4;
  localparam int STATE_W    = 2;

  // Trellis state: {u(t-1), u(t-2)}
  typedef logic [STATE_W-1:0] state_t;

  // Traceback controller states
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } tb_fsm_t;

  // Predecessor of state s given its survivor decision d.
  // This is the same mapping the ACS uses to pick survivors.
  function automatic state_t pred(input state_t s, input logic d);
    return {s[0], d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_traceback_if.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_traceback_if
// Brief    : Decision-input and decoded-output handshakes of the traceback.
// Revision : 1.0 - initial release
// ============================================================================
interface viterbi_traceback_if;
  import vit_k3_pkg::*;

  logic                  dec_valid;
  logic                  dec_ready;
  logic [NUM_STATES-1:0] dec_bits;
  state_t                best_state;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;

  // Master: ACS side feeding decisions and the sink consuming bits
  modport master (
    output dec_valid, dec_bits, best_state, out_ready,
    input  dec_ready, out_valid, out_bit
  );

  // Slave: the traceback unit
  modport slave (
    input  dec_valid, dec_bits, best_state, out_ready,
    output dec_ready, out_valid, out_bit
  );

endinterface
`default_nettype wire

// File: rtl/tb_survivor_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_survivor_mem
// Brief    : TB_LEN x 4 survivor decision store, sync write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_survivor_mem #(
  parameter int TB_LEN = 15,
  parameter int ADDR_W = $clog2(TB_LEN)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data
);

  logic [3:0] r_mem [TB_LEN];

  // Store one step's decisions; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/viterbi_traceback.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_traceback
// Brief    : Block traceback for the K=3 Viterbi decoder. Buffers TB_LEN
//            decision steps, walks back from the best final state, then
//            streams the decoded bits oldest-first.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_traceback
  import vit_k3_pkg::*;
#(
  parameter int TB_LEN = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  viterbi_traceback_if.slave  bus
);

  localparam int              PTR_W  = $clog2(TB_LEN);
  localparam logic [PTR_W-1:0] c_last = PTR_W'(TB_LEN - 1);
  localparam logic [PTR_W-1:0] c_one  = PTR_W'(1);

  tb_fsm_t           r_state;
  tb_fsm_t           w_next;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_tb_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  state_t            r_tb_state;
  logic [TB_LEN-1:0] r_obit;

  logic              w_dec_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_out_hs;
  logic [3:0]        w_rd_data;
  logic              w_surv_bit;

  assign w_accept   = bus.dec_valid && w_dec_ready;
  assign w_out_hs   = w_out_valid && bus.out_ready;
  assign w_surv_bit = w_rd_data[r_tb_state];

  tb_survivor_mem #(
    .TB_LEN (TB_LEN),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_accept),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.dec_bits),
    .rd_addr (r_tb_ptr),
    .rd_data (w_rd_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: fill a block, trace it back, drain it
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_accept && (r_wr_ptr == c_last)) w_next = TRACE;
      TRACE:   if (r_tb_ptr == '0)                    w_next = OUT;
      OUT:     if (w_out_hs && (r_rd_ptr == c_last))  w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // FSM outputs: handshakes decode from state only, no input feed-through
  always_comb begin
    w_dec_ready = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      FILL:    w_dec_ready = 1'b1;
      OUT:     w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Pointers and traceback state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_tb_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tb_state <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_wr_ptr == c_last) begin
              r_tb_state <= bus.best_state;
              r_tb_ptr   <= c_last;
            end else begin
              r_wr_ptr <= r_wr_ptr + c_one;
            end
          end
        end
        TRACE: begin
          r_tb_state <= pred(r_tb_state, w_surv_bit);
          r_tb_ptr   <= r_tb_ptr - c_one;
          if (r_tb_ptr == '0) begin
            r_rd_ptr <= '0;
          end
        end
        OUT: begin
          if (w_out_hs) begin
            if (r_rd_ptr == c_last) begin
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + c_one;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded bit of each step during traceback; storage is not reset
  always_ff @(posedge clk) begin
    if (r_state == TRACE) begin
      r_obit[r_tb_ptr] <= r_tb_state[1];
    end
  end

  assign bus.dec_ready = w_dec_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_bit   = w_out_valid ? r_obit[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_traceback
// Brief    : Self-checking bench for viterbi_traceback (TB_LEN=4 and 15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_traceback;
  import vit_k3_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  viterbi_traceback_if bus4 ();
  viterbi_traceback_if bus15 ();

  viterbi_traceback #(.TB_LEN(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  viterbi_traceback #(.TB_LEN(15)) dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic q4[$];
  logic q15[$];
  int   n_out;
  int   first_ov_cyc  = -1;
  int   first_acc_cyc = -1;
  int   last_acc_cyc  = -1;
  logic stall_prev = 1'b0;
  logic stall_bit  = 1'b0;
  logic last_acc, last_ov, last_ob, last_dr;

  // One clock cycle: drive after the edge, sample on the falling edge,
  // and score any output handshake against the expected-bit queue.
  task automatic step(input bit sel, input logic v, input logic [3:0] b,
                      input state_t bs, input logic rdy);
    logic exp;
    @(posedge clk);
    #1;
    cyc++;
    if (sel) begin
      bus15.dec_valid = v; bus15.dec_bits = b; bus15.best_state = bs; bus15.out_ready = rdy;
      bus4.dec_valid  = 1'b0; bus4.out_ready = 1'b0;
    end else begin
      bus4.dec_valid  = v; bus4.dec_bits = b; bus4.best_state = bs; bus4.out_ready = rdy;
      bus15.dec_valid = 1'b0; bus15.out_ready = 1'b0;
    end
    @(negedge clk);
    if (sel) begin
      last_ov = bus15.out_valid; last_ob = bus15.out_bit; last_dr = bus15.dec_ready;
    end else begin
      last_ov = bus4.out_valid;  last_ob = bus4.out_bit;  last_dr = bus4.dec_ready;
    end
    last_acc = v && (last_dr === 1'b1);
    if (last_acc) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (last_ov === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (stall_prev === 1'b1) begin
      checks++;
      if (last_ov !== 1'b1 || last_ob !== stall_bit) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%b out_bit=%b, required 1 and %b", last_ov, last_ob, stall_bit);
      end
    end
    stall_prev = (last_ov === 1'b1) && !rdy;
    stall_bit  = last_ob;
    if (last_ov === 1'b1 && rdy) begin
      n_out++;
      checks++;
      if ((sel && q15.size() == 0) || (!sel && q4.size() == 0)) begin
        errors++;
        $display("FAIL out_unexpected: out_bit=%b with no bit expected", last_ob);
      end else begin
        if (sel) exp = q15.pop_front(); else exp = q4.pop_front();
        if (last_ob !== exp) begin
          errors++;
          $display("FAIL out_bit: got %b, required %b (cycle %0d)", last_ob, exp, cyc);
        end
      end
    end
  endtask

  // Present each step until accepted; best_state is junk except on the last step
  task automatic drive_block(input bit sel, input logic [3:0] blk[$], input state_t bs);
    int guard;
    first_acc_cyc = -1;
    foreach (blk[i]) begin
      guard = 0;
      do begin
        step(sel, 1'b1, blk[i], (i == blk.size() - 1) ? bs : state_t'($urandom_range(0, 3)), 1'b1);
        guard++;
      end while (!last_acc && guard < 100);
      if (!last_acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout: step %0d not accepted in %0d cycles", i, guard);
        return;
      end
    end
  endtask

  // Collect n outputs; ready pattern advances only on cycles with out_valid
  task automatic drive_outputs(input bit sel, input int n, input logic [15:0] pat,
                               input int plen, input logic v, input logic [3:0] b,
                               input logic chk_busy);
    int k;
    int guard;
    n_out = 0; first_ov_cyc = -1; k = 0; guard = 0;
    while (n_out < n && guard < 400) begin
      step(sel, v, b, 2'd0, pat[4'(k % plen)]);
      if (last_ov === 1'b1) k++;
      guard++;
      if (chk_busy) begin
        checks++;
        if (last_dr !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: dec_ready=%b during TRACE/OUT, required 0", last_dr);
        end
      end
    end
    if (n_out < n) begin
      checks++; errors++;
      $display("FAIL out_timeout: %0d of %0d bits seen", n_out, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_bit !== 1'b0 || bus4.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset4: ov=%b ob=%b dr=%b, required 0 0 1", bus4.out_valid, bus4.out_bit, bus4.dec_ready);
    end
    checks++;
    if (bus15.out_valid !== 1'b0 || bus15.out_bit !== 1'b0 || bus15.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset15: ov=%b ob=%b dr=%b, required 0 0 1", bus15.out_valid, bus15.out_bit, bus15.dec_ready);
    end
  endtask

  task automatic test_known_path();
    logic [3:0] blk[$];
    blk = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    q4.push_back(1'b1); q4.push_back(1'b0); q4.push_back(1'b1); q4.push_back(1'b1);
    drive_block(1'b0, blk, 2'd3);
    drive_outputs(1'b0, 4, 16'h1, 1, 1'b0, 4'h0, 1'b1);
    checks++;
    if (first_ov_cyc - last_acc_cyc != 5) begin
      errors++;
      $display("FAIL latency: out_valid %0d cycles after last accept, required 5", first_ov_cyc - last_acc_cyc);
    end
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
    checks++;
    if (last_dr !== 1'b1 || last_ov !== 1'b0) begin
      errors++;
      $display("FAIL ready_return: dec_ready=%b out_valid=%b, required 1 0", last_dr, last_ov);
    end
  endtask

  task automatic test_all_zero();
    logic [3:0] blk[$];
    blk.delete();
    for (int i = 0; i < 15; i++) begin
      blk.push_back(4'b0000);
      q15.push_back(1'b0);
    end
    drive_block(1'b1, blk, 2'd0);
    drive_outputs(1'b1, 15, 16'h1, 1, 1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [3:0] blk[$];
    blk = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    q4.push_back(1'b1); q4.push_back(1'b0); q4.push_back(1'b1); q4.push_back(1'b1);
    drive_block(1'b0, blk, 2'd3);
    // ready sequence 1,0,0,1,0,1,1 with junk decisions offered throughout
    drive_outputs(1'b0, 4, 16'b0000000001101001, 7, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] blk[$];
    int hs_cyc;
    blk = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    for (int n = 0; n < 2; n++) begin
      q4.push_back(1'b1); q4.push_back(1'b0); q4.push_back(1'b1); q4.push_back(1'b1);
    end
    drive_block(1'b0, blk, 2'd3);
    drive_outputs(1'b0, 4, 16'h1, 1, 1'b1, blk[0], 1'b1);
    hs_cyc = cyc;
    drive_block(1'b0, blk, 2'd3);
    checks++;
    if (first_acc_cyc != hs_cyc + 1) begin
      errors++;
      $display("FAIL b2b_accept: second block accepted at cycle %0d, required %0d", first_acc_cyc, hs_cyc + 1);
    end
    drive_outputs(1'b0, 4, 16'h1, 1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
  endtask

  // Random blocks from a forward trellis model: the decision stored for the
  // true next state points back to the true current state.
  task automatic test_random(input bit sel, input int len, input int nblk);
    logic [3:0]  blk[$];
    logic [15:0] pat;
    state_t      s, nx;
    logic        u;
    logic [3:0]  b;
    for (int n = 0; n < nblk; n++) begin
      blk.delete();
      s = state_t'($urandom_range(0, 3));
      for (int t = 0; t < len; t++) begin
        u     = 1'($urandom_range(0, 1));
        nx    = {u, s[1]};
        b     = 4'($urandom_range(0, 15));
        b[nx] = s[0];
        blk.push_back(b);
        if (sel) q15.push_back(u); else q4.push_back(u);
        s = nx;
      end
      pat = 16'($urandom_range(0, 65535)) | 16'h1;
      drive_block(sel, blk, s);
      drive_outputs(sel, len, pat, 6, 1'b0, 4'h0, 1'b1);
      step(sel, 1'b0, 4'h0, 2'd0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_trace();
    logic [3:0] blk[$];
    int stray;
    blk = '{4'b1111, 4'b0000, 4'b0100, 4'b1010};
    drive_block(1'b0, blk, 2'd3);
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
    rst_n = 1'b1;
    checks++;
    if (last_dr !== 1'b1 || last_ov !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: dec_ready=%b out_valid=%b, required 1 0", last_dr, last_ov);
    end
    stray = 0;
    repeat (10) begin
      step(1'b0, 1'b0, 4'h0, 2'd0, 1'b1);
      if (last_ov !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_reset_abort: out_valid seen %0d times after abort, required 0", stray);
    end
    test_random(1'b0, 4, 1);
  endtask

  initial begin
    bus4.dec_valid  = 1'b0; bus4.dec_bits  = 4'h0; bus4.best_state  = 2'd0; bus4.out_ready  = 1'b0;
    bus15.dec_valid = 1'b0; bus15.dec_bits = 4'h0; bus15.best_state = 2'd0; bus15.out_ready = 1'b0;
    test_reset();
    test_known_path();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_random(1'b0, 4, 4);
    test_random(1'b1, 15, 3);
    test_reset_mid_trace();
    checks++;
    if (q4.size() != 0 || q15.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d/%0d expected bits never produced, required 0/0", q4.size(), q15.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback unit for the K=3 (4-state) Viterbi decoder. It consumes the per-step survivor decision bits written by the add-compare-select / path-memory stage, and buffers one block of TB_LEN trellis steps. It then walks the trellis backward from the best final state and emits the TB_LEN decoded information bits oldest-first over a valid/ready handshake. It is the reading end of the survivor path memory and sits between the ACS/metric memory and the decoder output.

## Interface
Parameters:
- TB_LEN, 15, traceback block length in trellis steps; legal range 2..64.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- dec_valid  input  1  a trellis step is presented on dec_bits/best_state
- dec_ready  output  1  unit accepts a step this cycle
- dec_bits  input  4  survivor decision per state; bit s belongs to state s
- best_state  input  2  minimum-metric state for this step; used only on the TB_LEN-th step of a block
- out_valid  output  1  out_bit holds a decoded bit
- out_ready  input  1  downstream accepts out_bit
- out_bit  output  1  decoded information bit

## Operation
- Trellis convention: state s = {u(t-1), u(t-2)}; next state = {u(t), s[1]}; predecessor of s with decision d = {s[0], d}; decoded bit at a step = s[1] of that step's state.
- FSM has three states: FILL, TRACE, OUT.
- FILL:
  - dec_ready=1.
  - Each accepted step (dec_valid && dec_ready) writes dec_bits to mem[wr_ptr] and increments wr_ptr.
  - On the accept with wr_ptr==TB_LEN-1, latch best_state into tb_state, set tb_ptr=TB_LEN-1, and go to TRACE.
- TRACE:
  - dec_ready=0.
  - One step per cycle: obit[tb_ptr] <= tb_state[1]; tb_state <= {tb_state[0], mem[tb_ptr][tb_state]}; tb_ptr decrements.
  - After processing tb_ptr==0, go to OUT with rd_ptr=0.
- OUT:
  - dec_ready=0; out_valid=1; out_bit=obit[rd_ptr].
  - On out_valid && out_ready, rd_ptr increments.
  - On the handshake with rd_ptr==TB_LEN-1, go to FILL with wr_ptr=0.
- Pointers are $clog2(TB_LEN) bits wide. There is no wrap-around within a block; each block is independent, with no overlap between blocks.
- dec_valid during TRACE/OUT is ignored and nothing is written; the upstream must hold its data.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset (rst_n low at a clock edge): FSM=FILL; wr_ptr, tb_ptr, rd_ptr, tb_state = 0; out_valid=0; out_bit=0; dec_ready=1 from the first cycle after reset. The mem and obit contents are not reset.
- Reset asserted mid-FILL, TRACE or OUT aborts the block. The partial block is discarded and no further out_valid is produced for it.
- dec_ready and out_valid decode combinationally from FSM state only. There are no combinational paths from dec_valid or out_ready.
- Latency: the last accepted step is at cycle N. TRACE occupies cycles N+1..N+TB_LEN. out_valid first rises at N+TB_LEN+1.
- With out_ready held high, bits issue one per cycle. dec_ready returns to 1 in the cycle after the last output handshake.
- Throughput: one block per 3*TB_LEN cycles minimum.
- out_bit is stable while out_valid=1 and out_ready=0.

## Structure
- Shared package vit_k3_pkg holds:
  - NUM_STATES=4 and STATE_W=2;
  - the state typedef;
  - the FSM enum;
  - a pure function pred(state, d) = {state[0], d}, shared with the ACS.
- One sub-module, tb_survivor_mem: a TB_LEN x 4 register array with a write port (wr_en, wr_addr, wr_data) and an asynchronous read port (rd_addr, 4-bit rd_data). The state-indexed bit select is done in the parent.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out_bit=0, dec_ready=1 on release.
- Known path, TB_LEN=4, input bits 1,0,1,1 from state 0:
  - stimulus: dec_bits 4'b0000, 4'b0000, 4'b0100, 4'b0000, with best_state=3 on the last step;
  - required: out_bit sequence 1,0,1,1;
  - required: first out_valid exactly 5 cycles after the last accept.
- All-zero stream, TB_LEN=15: every dec_bits=0, best_state=0 -> 15 zeros out; dec_ready=0 throughout TRACE/OUT.
- Backpressure: in the known-path case, toggle out_ready 1,0,0,1,0,1,1 -> the same 1,0,1,1 sequence, with out_bit held stable while stalled; dec_valid asserted during OUT writes nothing.
- Back-to-back blocks: two known-path blocks sent with dec_valid held high -> 8 outputs 1,0,1,1,1,0,1,1; the second block starts being accepted the cycle after the 4th output handshake.
- Reset mid-TRACE: after 2 TRACE cycles, pulse rst_n=0 -> next cycle FSM=FILL, out_valid stays 0, and a fresh block then decodes correctly.
